// File: rtl/gpu_mem_arbiter.sv
`timescale 1ns/1ps
// Two-client arbiter in front of the GPU-to-DDR adapter: grants one request at a time,
// holds the command stable until the adapter finishes, and routes read data back.
module gpu_mem_arbiter #(
   parameter int FIXED_PRIORITY = 0,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_pReq,
   input  logic [1:0]        i_pWrite,
   input  logic [1:0][1:0]   i_pSize,
   input  logic [1:0][14:0]  i_pAdr,
   input  logic [1:0][2:0]   i_pSub,
   input  logic [1:0][15:0]  i_pMask,
   input  logic [1:0][255:0] i_pData,
   output logic [1:0]        o_pAck,
   output logic [1:0]        o_pDataValid,
   output logic [1:0][255:0] o_pData,
   output logic              o_command,
   output logic              o_writeElseRead,
   output logic [1:0]        o_commandSize,
   output logic [14:0]       o_targetAddr,
   output logic [2:0]        o_subAddr,
   output logic [15:0]       o_writeMask,
   output logic [255:0]      o_dataClient,
   input  logic              i_busyClient,
   input  logic              i_dataValidClient,
   input  logic [255:0]      i_dataClient,
   output logic              o_timeoutErr,
   output logic              o_busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WAIT = 2'd2} stateType;

   stateType       stateReg;
   logic           lastGrantReg;
   logic           ownerReg;
   logic           holdWriteReg;
   logic [1:0]     holdSizeReg;
   logic [14:0]    holdAdrReg;
   logic [2:0]     holdSubReg;
   logic [15:0]    holdMaskReg;
   logic [255:0]   holdDataReg;
   logic           commandReg;
   logic           busyReg;
   logic           timeoutErrReg;
   logic [15:0]    waitCntReg;

   logic           grantPort;
   logic           grantValid;
   logic           readDone;
   logic           writeDone;
   logic           timeoutHit;
   logic [15:0]    waitCntNext;

   always_comb begin
      grantPort = i_pReq[1];
      if (i_pReq == 2'b11) begin
         grantPort = (FIXED_PRIORITY != 0) ? 1'b0 : ~lastGrantReg;
      end
   end

   assign grantValid  = (stateReg == IDLE) && (|i_pReq) && !i_busyClient && !i_rst;
   assign readDone    = (stateReg == WAIT) && !holdWriteReg && i_dataValidClient && !i_rst;
   assign writeDone   = (stateReg == WAIT) && holdWriteReg && !i_busyClient;
   // The counter never exceeds TIMEOUT_CYCLES-1, so the 16-bit increment cannot wrap.
   assign waitCntNext = waitCntReg + 16'd1;
   assign timeoutHit  = (stateReg == WAIT) && (waitCntNext == 16'(TIMEOUT_CYCLES));

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gPort
         assign o_pAck[gi]       = grantValid && (grantPort == 1'(gi));
         assign o_pDataValid[gi] = readDone && (ownerReg == 1'(gi));
         assign o_pData[gi]      = i_dataClient;
      end
   endgenerate

   assign o_command       = commandReg;
   assign o_writeElseRead = holdWriteReg;
   assign o_commandSize   = holdSizeReg;
   assign o_targetAddr    = holdAdrReg;
   assign o_subAddr       = holdSubReg;
   assign o_writeMask     = holdMaskReg;
   assign o_dataClient    = holdDataReg;
   assign o_timeoutErr    = timeoutErrReg;
   assign o_busy          = busyReg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stateReg      <= IDLE;
         lastGrantReg  <= 1'b1;
         ownerReg      <= 1'b0;
         holdWriteReg  <= 1'b0;
         holdSizeReg   <= 2'd0;
         holdAdrReg    <= 15'd0;
         holdSubReg    <= 3'd0;
         holdMaskReg   <= 16'd0;
         holdDataReg   <= 256'd0;
         commandReg    <= 1'b0;
         busyReg       <= 1'b0;
         timeoutErrReg <= 1'b0;
         waitCntReg    <= 16'd0;
      end else begin
         case (stateReg)
            IDLE: begin
               if (grantValid) begin
                  holdWriteReg <= i_pWrite[grantPort];
                  holdSizeReg  <= i_pSize[grantPort];
                  holdAdrReg   <= i_pAdr[grantPort];
                  holdSubReg   <= i_pSub[grantPort];
                  holdMaskReg  <= i_pMask[grantPort];
                  holdDataReg  <= i_pData[grantPort];
                  ownerReg     <= grantPort;
                  lastGrantReg <= grantPort;
                  commandReg   <= 1'b1;
                  busyReg      <= 1'b1;
                  stateReg     <= CMD;
               end
            end
            CMD: begin
               commandReg <= 1'b0;
               waitCntReg <= 16'd0;
               stateReg   <= WAIT;
            end
            WAIT: begin
               // Completion on the final allowed cycle wins over the timeout.
               if (readDone || writeDone) begin
                  busyReg  <= 1'b0;
                  stateReg <= IDLE;
               end else if (timeoutHit) begin
                  timeoutErrReg <= 1'b1;
                  busyReg       <= 1'b0;
                  stateReg      <= IDLE;
               end else begin
                  waitCntReg <= waitCntNext;
               end
            end
            default: begin
               busyReg  <= 1'b0;
               stateReg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
`timescale 1ns/1ps
// Randomized bench for gpu_mem_arbiter: a transaction-level timeline model predicts grants,
// command/busy windows, data returns and timeouts; a second instance covers fixed priority.
module tb_gpu_mem_arbiter;

   localparam int TMO   = 8;
   localparam int NEVER = 1 << 30;

   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic              i_rst;
   logic [1:0]        i_pReq, i_pWrite;
   logic [1:0][1:0]   i_pSize;
   logic [1:0][14:0]  i_pAdr;
   logic [1:0][2:0]   i_pSub;
   logic [1:0][15:0]  i_pMask;
   logic [1:0][255:0] i_pData;
   logic              i_busyClient, i_dataValidClient;
   logic [255:0]      i_dataClient;

   logic [1:0]        o_pAck, o_pDataValid;
   logic [1:0][255:0] o_pData;
   logic              o_command, o_writeElseRead, o_timeoutErr, o_busy;
   logic [1:0]        o_commandSize;
   logic [14:0]       o_targetAddr;
   logic [2:0]        o_subAddr;
   logic [15:0]       o_writeMask;
   logic [255:0]      o_dataClient;

   logic [1:0]        fpAck, fpDv;
   logic [1:0][255:0] fpData;
   logic              fpCmd, fpWr, fpErr, fpBusy;
   logic [1:0]        fpSize;
   logic [14:0]       fpAdr;
   logic [2:0]        fpSub;
   logic [15:0]       fpMask;
   logic [255:0]      fpDataOut;

   gpu_mem_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_pReq(i_pReq), .i_pWrite(i_pWrite), .i_pSize(i_pSize),
      .i_pAdr(i_pAdr), .i_pSub(i_pSub), .i_pMask(i_pMask), .i_pData(i_pData),
      .o_pAck(o_pAck), .o_pDataValid(o_pDataValid), .o_pData(o_pData),
      .o_command(o_command), .o_writeElseRead(o_writeElseRead), .o_commandSize(o_commandSize),
      .o_targetAddr(o_targetAddr), .o_subAddr(o_subAddr), .o_writeMask(o_writeMask),
      .o_dataClient(o_dataClient), .i_busyClient(i_busyClient),
      .i_dataValidClient(i_dataValidClient), .i_dataClient(i_dataClient),
      .o_timeoutErr(o_timeoutErr), .o_busy(o_busy));

   gpu_mem_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(TMO)) dutFp (
      .i_clk(i_clk), .i_rst(i_rst), .i_pReq(i_pReq), .i_pWrite(i_pWrite), .i_pSize(i_pSize),
      .i_pAdr(i_pAdr), .i_pSub(i_pSub), .i_pMask(i_pMask), .i_pData(i_pData),
      .o_pAck(fpAck), .o_pDataValid(fpDv), .o_pData(fpData),
      .o_command(fpCmd), .o_writeElseRead(fpWr), .o_commandSize(fpSize),
      .o_targetAddr(fpAdr), .o_subAddr(fpSub), .o_writeMask(fpMask),
      .o_dataClient(fpDataOut), .i_busyClient(i_busyClient),
      .i_dataValidClient(i_dataValidClient), .i_dataClient(i_dataClient),
      .o_timeoutErr(fpErr), .o_busy(fpBusy));

   int vecCount = 0;
   int errCount = 0;

   // client request registers
   logic [1:0]        pend, pW;
   logic [1:0][1:0]   pSz;
   logic [1:0][14:0]  pAdr;
   logic [1:0][2:0]   pSub;
   logic [1:0][15:0]  pMask;
   logic [1:0][255:0] pData;

   // scenario controls
   logic rstNow, forceBusy, spurDv, contReq, fpPhase, checking;
   int   nextN;
   logic nextResp;
   logic [255:0] nextData;

   // timeline model: cycle stamps of the current transaction
   int cyc, mGrantCyc, mFreeAt, mCmdCyc, mDvCyc, mErrFrom, mOwner, mLast, txnCount;
   logic         hW;
   logic [1:0]   hSz;
   logic [14:0]  hAdr;
   logic [2:0]   hSub;
   logic [15:0]  hMask;
   logic [255:0] hData;

   // adapter behaviour for the transaction in flight
   int aBusyStart, aBusyEnd, aDvCyc;
   logic [255:0] aData;

   task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
      vecCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic setReq(input int p, input logic w, input logic [1:0] sz,
                         input logic [14:0] adr, input logic [15:0] mask);
      pend[p]  = 1'b1;
      pW[p]    = w;
      pSz[p]   = sz;
      pAdr[p]  = adr;
      pSub[p]  = 3'($urandom_range(0, 7));
      pMask[p] = mask;
      pData[p] = rand256();
   endtask

   task automatic modelReset();
      mGrantCyc = cyc;
      mFreeAt   = cyc + 1;
      mCmdCyc   = -1;
      mDvCyc    = -1;
      mErrFrom  = NEVER;
      mLast     = 1;
      mOwner    = 0;
      hW = 1'b0; hSz = '0; hAdr = '0; hSub = '0; hMask = '0; hData = '0;
   endtask

   task automatic runCycle();
      logic       grant;
      int         g, c, exitCyc;
      logic       timedOut;
      logic [1:0] expAck, expDv;
      @(posedge i_clk);
      #1;
      cyc++;
      i_rst             = rstNow;
      i_busyClient      = forceBusy || (cyc >= aBusyStart && cyc <= aBusyEnd);
      i_dataValidClient = (cyc == aDvCyc) || (spurDv && cyc >= mFreeAt);
      i_dataClient      = (cyc == aDvCyc) ? aData : rand256();
      i_pReq = pend; i_pWrite = pW; i_pSize = pSz; i_pAdr = pAdr;
      i_pSub = pSub; i_pMask = pMask; i_pData = pData;
      @(negedge i_clk);

      grant = !rstNow && cyc >= mFreeAt && i_pReq != 2'b00 && !i_busyClient;
      g = (i_pReq == 2'b11) ? (1 - mLast) : (i_pReq[1] ? 1 : 0);
      expAck = grant ? 2'(2'b01 << g) : 2'b00;
      expDv  = (!rstNow && cyc == mDvCyc) ? 2'(2'b01 << mOwner) : 2'b00;

      if (checking) begin
         checkVal("ack", 256'(o_pAck), 256'(expAck));
         checkVal("dataValid", 256'(o_pDataValid), 256'(expDv));
         if (expDv != 2'b00) checkVal("readData", o_pData[mOwner], aData);
         checkVal("command", 256'(o_command), 256'(cyc == mCmdCyc));
         checkVal("busy", 256'(o_busy), 256'(cyc > mGrantCyc && cyc < mFreeAt));
         checkVal("timeoutErr", 256'(o_timeoutErr), 256'(cyc >= mErrFrom));
         checkVal("cmdFields",
                  256'({o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr, o_writeMask}),
                  256'({hW, hSz, hAdr, hSub, hMask}));
         checkVal("writeData", o_dataClient, hData);
         if (fpPhase) begin
            checkVal("fixedAck", 256'(fpAck), 256'(grant ? 2'b01 : 2'b00));
            checkVal("fixedDataValid", 256'(fpDv), 256'(expDv != 2'b00 ? 2'b01 : 2'b00));
            if (expDv != 2'b00) checkVal("fixedReadData", fpData[0], aData);
            checkVal("fixedCommand", 256'(fpCmd), 256'(cyc == mCmdCyc));
            checkVal("fixedBusy", 256'(fpBusy), 256'(cyc > mGrantCyc && cyc < mFreeAt));
            checkVal("fixedTimeoutErr", 256'(fpErr), 256'(cyc >= mErrFrom));
         end
      end

      for (int p = 0; p < 2; p++) begin
         if (o_pAck[p] && !contReq) pend[p] = 1'b0;
      end

      if (rstNow) begin
         modelReset();
      end else if (grant) begin
         c         = cyc + 1;
         mGrantCyc = cyc;
         mCmdCyc   = c;
         mOwner    = g;
         mLast     = g;
         hW = i_pWrite[g]; hSz = i_pSize[g]; hAdr = i_pAdr[g];
         hSub = i_pSub[g]; hMask = i_pMask[g]; hData = i_pData[g];
         aBusyStart = c + 1;
         aBusyEnd   = c + nextN;
         aData      = nextData;
         timedOut   = 1'b0;
         mDvCyc     = -1;
         if (hW) begin
            aDvCyc = -1;
            if (nextN + 1 <= TMO) exitCyc = c + nextN + 1;
            else begin exitCyc = c + TMO; timedOut = 1'b1; end
         end else begin
            aDvCyc = nextResp ? c + nextN + 1 : -1;
            if (nextResp && nextN + 1 <= TMO) begin
               exitCyc = c + nextN + 1;
               mDvCyc  = exitCyc;
            end else begin
               exitCyc  = c + TMO;
               timedOut = 1'b1;
            end
         end
         mFreeAt = exitCyc + 1;
         if (timedOut && mErrFrom == NEVER) mErrFrom = exitCyc + 1;
         txnCount++;
         $display("txn %0d cycle %0d: port %0d %s size %0d adr %h busy %0d resp %0d timeout %0d",
                  txnCount, cyc, g, hW ? "write" : "read", hSz, hAdr, nextN, nextResp, timedOut);
      end
   endtask

   initial begin
      i_rst = 1'b1; i_pReq = '0; i_pWrite = '0; i_pSize = '0; i_pAdr = '0; i_pSub = '0;
      i_pMask = '0; i_pData = '0; i_busyClient = 1'b0; i_dataValidClient = 1'b0; i_dataClient = '0;
      pend = '0; pW = '0; pSz = '0; pAdr = '0; pSub = '0; pMask = '0; pData = '0;
      rstNow = 1'b1; forceBusy = 1'b0; spurDv = 1'b0; contReq = 1'b0; fpPhase = 1'b0; checking = 1'b0;
      nextN = 0; nextResp = 1'b1; nextData = '0;
      cyc = 0; txnCount = 0;
      aBusyStart = NEVER; aBusyEnd = -1; aDvCyc = -1; aData = '0;
      modelReset();

      // reset state
      repeat (2) runCycle();
      checking = 1'b1;
      runCycle();
      rstNow = 1'b0;

      // port-0 32 B read at 0x1234, six busy cycles, data AA..AA
      setReq(0, 1'b0, 2'd1, 15'h1234, 16'h0000);
      nextN = 6; nextResp = 1'b1; nextData = {32{8'hAA}};
      repeat (12) runCycle();

      // port-1 masked write held off by a busy adapter, then four busy WAIT cycles
      forceBusy = 1'b1;
      setReq(1, 1'b1, 2'd1, 15'($urandom()), 16'h00F0);
      nextN = 4;
      repeat (4) runCycle();
      forceBusy = 1'b0;
      repeat (10) runCycle();

      // read that never returns, then a normal read with the flag still set
      setReq(0, 1'b0, 2'd2, 15'($urandom()), 16'h0000);
      nextN = 3; nextResp = 1'b0;
      repeat (12) runCycle();
      setReq(1, 1'b0, 2'd0, 15'($urandom()), 16'h0000);
      nextN = 2; nextResp = 1'b1; nextData = rand256();
      repeat (8) runCycle();

      // data arriving after the timeout must be ignored
      setReq(0, 1'b0, 2'd3, 15'($urandom()), 16'h0000);
      nextN = 9; nextResp = 1'b1; nextData = rand256();
      repeat (14) runCycle();

      // reset in the middle of a read WAIT
      setReq(0, 1'b0, 2'd1, 15'($urandom()), 16'h0000);
      nextN = 6; nextResp = 1'b1; nextData = rand256();
      repeat (4) runCycle();
      rstNow = 1'b1;
      runCycle();
      rstNow = 1'b0;
      repeat (12) runCycle();

      // both ports requesting continuously: alternation vs fixed priority
      rstNow = 1'b1;
      runCycle();
      rstNow = 1'b0;
      contReq = 1'b1; fpPhase = 1'b1;
      setReq(0, 1'b0, 2'd1, 15'($urandom()), 16'h0000);
      setReq(1, 1'b0, 2'd1, 15'($urandom()), 16'h0000);
      nextN = 2; nextResp = 1'b1; nextData = rand256();
      repeat (40) runCycle();
      contReq = 1'b0; fpPhase = 1'b0; pend = '0;
      repeat (10) runCycle();

      // randomized traffic
      for (int k = 0; k < 800; k++) begin
         for (int p = 0; p < 2; p++) begin
            if (pend[p] && $urandom_range(0, 31) == 0) pend[p] = 1'b0;
            else if (!pend[p] && $urandom_range(0, 3) == 0)
               setReq(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      15'($urandom()), 16'($urandom()));
         end
         nextN = $urandom_range(0, 9);
         if (nextN >= 7) nextN++;
         nextResp = ($urandom_range(0, 7) != 0);
         nextData = rand256();
         spurDv   = ($urandom_range(0, 15) == 0);
         rstNow   = ($urandom_range(0, 199) == 0);
         runCycle();
      end
      rstNow = 1'b0; spurDv = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule
